// File: rtl/stream_source_if.sv
// stream_source_if: downstream valid/ready stream carrying D_WIDTH-bit words.
//   valid : word present on data (driven by source)
//   ready : consumer accepts the word (driven by sink)
//   data  : payload (driven by source)
interface stream_source_if #(
  parameter int D_WIDTH = 6
);
  logic               valid;
  logic               ready;
  logic [D_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_source.sv
// stream_source: emits runs of LEN incrementing words (k mod 2^D_WIDTH) on a
// valid/ready stream, optionally gated by an 8-bit LFSR to create gaps.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : run request, sampled only in IDLE
//   down     : stream master (valid, data out; ready in)
//   busy     : high while in RUN
//   done     : one-cycle pulse after the last transfer
//   sent_cnt : transfers in the current or most recent run
module stream_source #(
  parameter int         D_WIDTH  = 6,
  parameter int         LEN      = 16,
  parameter int         THROTTLE = 1,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  stream_source_if.master       down,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sent_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(LEN - 1);

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               gate;
  logic               xfer;

  always_comb begin
    gate    = (THROTTLE == 0) ? 1'b1 : lfsr_q[0];
    xfer    = valid_q & down.ready;
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          data_d  = '0;
          // Unthrottled runs present word 0 straight away so the last
          // transfer lands LEN edges after start.
          valid_d = (THROTTLE == 0);
        end
      end
      RUN: begin
        // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (xfer) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            data_d  = data_q + 1'b1;
            valid_d = gate;
          end
        end else if (!valid_q) begin
          valid_d = gate;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign down.valid = valid_q;
  assign down.data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_cnt   = cnt_q;

endmodule

// File: doc/stream_source.md
STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 Parameter D_WIDTH, default 6: payload width in bits.
REQ-002 Parameter LEN, default 16: words per run; legal range 1..65535.
REQ-003 Parameter THROTTLE, default 1: 0 = no gaps, 1 = LFSR-gated gaps on down_valid.
REQ-004 Parameter SEED, default 8'hA5: LFSR reset value; must be non-zero.
REQ-005 Port clk  input  1  sole clock; all logic is clocked on the rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port start  input  1  run request; sampled only in IDLE.
REQ-008 Port down_valid  output  1  word present on down_data.
REQ-009 Port down_ready  input  1  consumer accepts the word.
REQ-010 Port down_data  output  D_WIDTH  payload.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  one-cycle pulse after the last transfer.
REQ-013 Port sent_cnt  output  16  number of transfers in the current or most recent run.

Function
REQ-014 A transfer occurs on any rising edge where down_valid=1 and down_ready=1.
REQ-015 State machine has three states: IDLE, RUN, DONE.
REQ-016 State transitions:
- IDLE->RUN on start=1.
- RUN->DONE on the transfer that makes sent_cnt equal LEN.
- DONE->IDLE unconditionally after one cycle.
REQ-017 start is ignored in RUN and DONE.
REQ-018 start in IDLE at edge n: busy=1, sent_cnt=0, down_data=0 from cycle n+1.
REQ-019 Gate signal G:
- THROTTLE=0: G=1.
- THROTTLE=1: G=lfsr[0].
REQ-020 The LFSR is 8 bits, taps x^8+x^6+x^5+x^4+1, Fibonacci form, and steps every cycle in RUN only.
REQ-021 All outputs are registered; down_valid follows these rules:
- It rises at the next edge only when in RUN with down_valid=0 and G=1.
- While down_valid=1 and down_ready=0, down_valid and down_data hold stable, regardless of the LFSR.
REQ-022 On a non-final transfer, the next edge behaves as follows:
- down_data increments by 1, modulo 2^D_WIDTH.
- sent_cnt increments by 1.
- down_valid takes the value of G, so back-to-back transfers are possible.
REQ-023 With THROTTLE=0 and down_ready held at 1, throughput is one word per cycle.
- First down_valid appears at n+1.
- Last transfer occurs at edge n+LEN.
REQ-024 On the final transfer:
- down_valid=0 at the next edge.
- done=1 for exactly that one cycle (DONE state).
- busy=0.
REQ-025 Word k of a run (k = 0..LEN-1) carries the value k mod 2^D_WIDTH; wrap-around from 2^D_WIDTH-1 to 0 is legal.
REQ-026 sent_cnt holds its final value in DONE and IDLE until the next accepted start.
REQ-027 down_data is don't-care when down_valid=0 but shall not change except on transfer or start.
REQ-028 down_ready while down_valid=0 has no effect.
REQ-029 LEN=1 case: the first transfer is also the final one (RUN->DONE directly).

Reset
REQ-030 rst=1 at a rising edge forces the following values, overriding all other inputs including start:
- state=IDLE
- down_valid=0, down_data=0
- busy=0, done=0
- sent_cnt=0
- lfsr=SEED
REQ-031 rst asserted mid-run aborts the run.
- No done pulse is issued.
- A pending unaccepted word is dropped.
- The next run restarts at data 0.
REQ-032 The first start is accepted on the first edge with rst=0.

Verification
REQ-033 Back-to-back test: THROTTLE=0, LEN=4, down_ready=1, start pulse at edge 0 -> down_data 0,1,2,3 valid on cycles 1-4, done=1 on cycle 5, sent_cnt=4.
REQ-034 Backpressure test: THROTTLE=0, down_ready=0 for 3 cycles after valid rises -> down_valid=1 and down_data=0 held stable all 3 cycles, then transfers proceed.
REQ-035 Wrap-around test: D_WIDTH=6, LEN=70, down_ready=1 -> word 64 carries 0, word 69 carries 5, sent_cnt=70, single done pulse.
REQ-036 Throttled test: THROTTLE=1, SEED=8'hA5, down_ready=1 -> gaps match the reference LFSR sequence; valid never drops without a transfer; total 16 words in order.
REQ-037 Reset mid-run: rst at word 5 with a word pending -> next cycle all outputs 0; a new start yields data 0 first, done only at the end of the new run.
REQ-038 Start-during-run test: start pulsed during RUN and DONE -> no effect; exactly LEN words and one done pulse.
